// File: rtl/data_mem_io_pkg.sv
// Shared constants for the memory stage: bus widths, RAM geometry, I/O map,
// address-region decode and 7-segment glyphs.
package data_mem_io_pkg;

  localparam int DBITS        = 32;
  localparam int DMEMADDRBITS = 13;
  localparam int DMEMWORDBITS = 2;
  localparam int DMEMWORDS    = 2048;
  // Initial RAM image; it is bound to the RAM by the FPGA build flow.
  localparam string DMEM_INIT_FILE = "Sorter2.mif";

  localparam logic [DBITS-1:0] ADDR_HEX  = 32'hF000_0000;
  localparam logic [DBITS-1:0] ADDR_LEDR = 32'hF000_0004;
  localparam logic [DBITS-1:0] ADDR_LEDG = 32'hF000_0008;
  localparam logic [DBITS-1:0] ADDR_KEY  = 32'hF000_0010;
  localparam logic [DBITS-1:0] ADDR_SW   = 32'hF000_0014;

  localparam logic [6:0] SEG_RESET = 7'b1000000;

  typedef enum logic [2:0] {
    RGN_NONE, RGN_RAM, RGN_HEX, RGN_LEDR, RGN_LEDG, RGN_KEY, RGN_SW
  } region_e;

  // I/O addresses match on the word address; the RAM window is addr < 2^13.
  function automatic region_e decode_addr(input logic [DBITS-1:0] a);
    logic [DBITS-1:0] w;
    w = {a[DBITS-1:DMEMWORDBITS], {DMEMWORDBITS{1'b0}}};
    if      (w == ADDR_HEX)  return RGN_HEX;
    else if (w == ADDR_LEDR) return RGN_LEDR;
    else if (w == ADDR_LEDG) return RGN_LEDG;
    else if (w == ADDR_KEY)  return RGN_KEY;
    else if (w == ADDR_SW)   return RGN_SW;
    else if (a[DBITS-1:DMEMADDRBITS] == '0) return RGN_RAM;
    else return RGN_NONE;
  endfunction

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_io_if.sv
// Load/store bus between the execute stage and the memory stage.
interface data_mem_io_if;
  import data_mem_io_pkg::*;

  logic [DBITS-1:0] memAddr;
  logic             memWrtEn;
  logic [DBITS-1:0] memWrtData;
  logic [DBITS-1:0] memReadData;

  modport master (output memAddr, memWrtEn, memWrtData, input memReadData);
  modport slave  (input memAddr, memWrtEn, memWrtData, output memReadData);
endinterface

// File: rtl/data_mem_io_seven_seg.sv
// One hex digit to active-low 7-segment pattern.
module data_mem_io_seven_seg
  import data_mem_io_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = seg7(i_nib);
endmodule

// File: rtl/data_mem_io.sv
// Memory stage: 2048-word data RAM plus memory-mapped KEY/SW/HEX/LED registers,
// input synchronisers, switch debouncer and 7-segment drivers.
module data_mem_io
  import data_mem_io_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic         clk,
  input  logic         reset,
  data_mem_io_if.slave bus,
  input  logic [9:0]   SW,
  input  logic [3:0]   KEY,
  output logic [9:0]   LEDR,
  output logic [7:0]   LEDG,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX3
);

  localparam int IDXW = DMEMADDRBITS - DMEMWORDBITS;

  logic [DBITS-1:0] r_mem [DMEMWORDS];
  logic [15:0]      r_hex;
  logic [9:0]       r_ledr;
  logic [7:0]       r_ledg;
  logic [3:0]       r_key_s1, r_key_s2;
  logic [9:0]       r_sw_s1, r_sw_s2, r_sw_stable;
  logic [15:0]      r_db_cnt;

  region_e          w_rgn;
  logic [IDXW-1:0]  w_idx;
  logic             w_wr;
  logic [DBITS-1:0] w_rdata;
  logic [3:0][6:0]  w_seg;

  assign w_rgn = decode_addr(bus.memAddr);
  assign w_idx = bus.memAddr[DMEMADDRBITS-1:DMEMWORDBITS];
  assign w_wr  = bus.memWrtEn && !reset;

  // RAM contents survive reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (w_wr && w_rgn == RGN_RAM) r_mem[w_idx] <= bus.memWrtData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex  <= '0;
      r_ledr <= '0;
      r_ledg <= '0;
    end else if (w_wr) begin
      case (w_rgn)
        RGN_HEX:  r_hex  <= bus.memWrtData[15:0];
        RGN_LEDR: r_ledr <= bus.memWrtData[9:0];
        RGN_LEDG: r_ledg <= bus.memWrtData[7:0];
        default: ;
      endcase
    end
  end

  // Synchronisers; the debouncer commits once swSync has differed from the
  // stable value for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_s1    <= 4'hF;
      r_key_s2    <= 4'hF;
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
      r_sw_stable <= '0;
      r_db_cnt    <= '0;
    end else begin
      r_key_s1 <= KEY;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
      if (r_sw_s2 == r_sw_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        r_sw_stable <= r_sw_s2;
        r_db_cnt    <= '0;
      end else if (r_db_cnt != 16'hFFFF) begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_rgn)
      RGN_RAM:  w_rdata = r_mem[w_idx];
      RGN_HEX:  w_rdata = {16'b0, r_hex};
      RGN_LEDR: w_rdata = {22'b0, r_ledr};
      RGN_LEDG: w_rdata = {24'b0, r_ledg};
      RGN_KEY:  w_rdata = {28'b0, ~r_key_s2};
      RGN_SW:   w_rdata = {22'b0, r_sw_stable};
      default:  w_rdata = '0;
    endcase
  end
  assign bus.memReadData = w_rdata;

  for (genvar g = 0; g < 4; g++) begin : g_hex
    data_mem_io_seven_seg u_seg (.i_nib(r_hex[4*g +: 4]), .o_seg(w_seg[g]));
  end

  assign HEX0 = w_seg[0];
  assign HEX1 = w_seg[1];
  assign HEX2 = w_seg[2];
  assign HEX3 = w_seg[3];
  assign LEDR = r_ledr;
  assign LEDG = r_ledg;

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
Memory stage of the single-cycle processor, directly downstream of the execute stage. It consumes the ALU result as a data address, the second register operand as store data and the store strobe, and returns load data for register writeback. It contains the 2048-word data RAM and the memory-mapped I/O registers for KEY, SW, HEX and LEDR/LEDG. It also contains the input synchronisers, the switch debouncer and the 7-segment drivers.

Parameters:
DBITS, 32, data/address width
DMEMADDRBITS, 13, byte-address bits decoded for data RAM
DMEMWORDBITS, 2, byte-offset bits dropped for word indexing
DMEMWORDS, 2048, RAM depth in words
DMEM_INIT_FILE, "Sorter2.mif", RAM initial contents
ADDR_HEX / ADDR_LEDR / ADDR_LEDG / ADDR_KEY / ADDR_SW, 32'hF0000000 / 32'hF0000004 / 32'hF0000008 / 32'hF0000010 / 32'hF0000014, I/O addresses
DEBOUNCE_CYCLES, 16'd50000, stable cycles required before an SW change is accepted

Ports:
clk  in  1  system clock (PLL output)
reset  in  1  synchronous, active-high reset
memAddr  in  DBITS  byte address (ALU output)
memWrtEn  in  1  store strobe (OP1_SW)
memWrtData  in  DBITS  store data (rs2 value)
memReadData  out  DBITS  load data, combinational from memAddr
SW  in  10  raw board switches
KEY  in  4  raw board keys, active-low
LEDR  out  10  red LEDs
LEDG  out  8  green LEDs
HEX0..HEX3  out  7 each  active-low 7-segment digits; HEX0 is the least-significant nibble

Behaviour:
Interface:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.

Reset:
- Reset has priority over all writes.
- At reset: hexReg=0, so every HEX shows "0" (7'b1000000).
- At reset: LEDR=0, LEDG=0.
- At reset: KEY sync stages=4'b1111 (released); SW sync stages=0; swStable=0; debounce counter=0.
- RAM contents are not reset. No RAM write happens in any cycle where reset=1.

Address decode (full 32-bit compare, addr[1:0] ignored):
- addr == an I/O address: I/O region.
- addr[31:DMEMADDRBITS]==0: RAM, word index addr[DMEMADDRBITS-1:DMEMWORDBITS].
- Any other address: reads return 0, writes are ignored.

Reads:
- Combinational, same cycle as memAddr; needed by the single-cycle datapath.
- HEX returns {16'b0, hexReg}. LEDR and LEDG return their register value zero-extended.
- KEY returns {28'b0, ~keySync}, so a pressed key reads as 1.
- SW returns {22'b0, swStable}.

Writes:
- Take effect on the rising clk when memWrtEn=1 and reset=0.
- HEX takes memWrtData[15:0]; LEDR takes [9:0]; LEDG takes [7:0]. Upper bits are dropped.
- Writes to KEY or SW are ignored.
- Read and write to the same address in one cycle: the read returns old data; the new value is visible next cycle.

Outputs:
- LEDR, LEDG and HEX are registered, so they change 1 cycle after the store edge.
- HEXn = seg7(hexReg[4n+3:4n]), covering all 16 hex glyphs (0-9, A-F).

KEY path:
- 2-flop synchroniser; read value lags the pin by 2 cycles.

SW path:
- 2-flop synchroniser, then debounce.
- If swSync == swStable, the counter clears.
- Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, swStable<=swSync and the counter clears.
- Any bounce back to the swStable value before that point clears the counter.
- The counter saturates and does not wrap.

Decomposition:
- Shared package holds: I/O address constants, DMEM* sizes, DBITS, the 7-seg glyph constants, and the reset glyph.
- One natural sub-module, seven_seg: 4-bit nibble in, 7-bit active-low segments out, instantiated 4x.
- Synchronisers and the debouncer stay inline.

Test Plan:
- Reset: assert reset 2 cycles -> LEDR=0, LEDG=0, HEX0..3=7'b1000000, SW read=0, KEY read=0.
- RAM: store 32'hDEADBEEF at 32'h00000100, then load 32'h00000100 and 32'h00000103 -> both return 32'hDEADBEEF. Load 32'h00002100 -> returns 0, and RAM word 64 is unchanged.
- I/O store: store 32'hFFFF1234 to ADDR_HEX -> next cycle HEX3..HEX0 show 1,2,3,4 (7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001) and the HEX read returns 32'h00001234. Store 32'hFFF to ADDR_LEDR -> LEDR=10'h3FF.
- KEY: drive KEY=4'b1110 -> the ADDR_KEY read returns 32'h1 exactly 2 cycles later.
- SW debounce (DEBOUNCE_CYCLES=8 in bench): set SW=10'h2A5 -> read stays 0 until cycle 2+8, then returns 32'h2A5. Toggle SW for 5 cycles and revert -> read is unchanged.
- Priority: assert reset together with a store 32'h55 to ADDR_LEDG -> LEDG stays 0. Store to ADDR_SW -> the SW read is unaffected.
